// File: rtl/reg_scoreboard_pkg.sv
// Shared types and helpers for the register scoreboard.
// Defaults match the 16-register, dual-writeback decode->execute boundary.
// Optional feature macro used by importers: SCOREBOARD_BYPASS_EN.
package reg_scoreboard_pkg;

  localparam int SB_NUM_REGS_DEF = 16;
  localparam int SB_WB_PORTS_DEF = 2;
  localparam int SB_CNT_W_DEF    = 2;

  // Index width for n entries; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold a retire count of 0..n.
  function automatic int dec_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Issue request as seen from decode at the default geometry.
  typedef struct packed {
    logic [SB_NUM_REGS_DEF-1:0]        src_mask;
    logic                              dst_valid;
    logic [idx_w(SB_NUM_REGS_DEF)-1:0] dst;
  } sb_issue_t;

  typedef logic [SB_CNT_W_DEF-1:0] sb_cnt_t;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// Per-register in-flight writer counter: cnt <= clamp(cnt + inc - dec), clr wins.
// Latency: 1 cycle from inc/dec/clr to cnt; underflow flag is combinational.
// Backpressure: none; the caller must never assert inc at all-ones.
module sb_reg_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic [DEC_W-1:0] i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nonzero,
  output logic             o_underflow
);

  // One sign bit of headroom over the largest possible magnitude.
  localparam int SUM_W = CNT_W + DEC_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_sum;
  logic             w_neg;
  logic             w_over;
  logic [CNT_W-1:0] w_next;

  // Net arithmetic of issue and retire, then clamp into the counter range.
  always_comb begin
    w_sum  = SUM_W'(r_cnt) + SUM_W'(i_inc) - SUM_W'(i_dec);
    w_neg  = w_sum[SUM_W-1];
    w_over = !w_neg && (|w_sum[SUM_W-2:CNT_W]);
    if (i_clr || w_neg) w_next = '0;
    else if (w_over)    w_next = '1;
    else                w_next = w_sum[CNT_W-1:0];
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_next;
  end

  assign o_cnt       = r_cnt;
  assign o_nonzero   = |r_cnt;
  assign o_underflow = !i_clr && w_neg;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard / issue-stall controller between decode and execute.
// Latency: issue->busy 1 cycle; retire->busy clear 1 cycle (0 for readiness with SCOREBOARD_BYPASS_EN).
// Backpressure: issue_ready (combinational) drops on flush, RAW hazard, or full dst counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int WB_PORTS = 2,
  parameter  int CNT_W    = 2,
  parameter  int STALL_W  = 32,
  localparam int IDX_W    = idx_w(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [NUM_REGS-1:0]       issue_src_mask,
  input  logic                      issue_dst_valid,
  input  logic [IDX_W-1:0]          issue_dst,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0] wb_dst,
  input  logic                      flush,
  output logic [NUM_REGS-1:0]       busy,
  output logic [STALL_W-1:0]        stall_cycles,
  output logic                      sb_error
);

  localparam int DEC_W = dec_w(WB_PORTS);
  localparam int CMP_W = CNT_W + DEC_W;

  logic [CNT_W-1:0]   w_cnt     [NUM_REGS];
  logic [DEC_W-1:0]   w_dec     [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_nonzero;
  logic [NUM_REGS-1:0] w_underflow;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic               w_raw;
  logic               w_full;
  logic               w_fire;
  logic               r_sb_error;
  logic [STALL_W-1:0] r_stall;

  // Retire decode: count writeback ports targeting each register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_dec[r] = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_dst[p*IDX_W +: IDX_W] == IDX_W'(r)))
          w_dec[r] = w_dec[r] + DEC_W'(1);
      end
    end
  end

  // Hazard view of each register; bypass lets a same-cycle retire release it.
  always_comb begin
    w_full = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
`ifdef SCOREBOARD_BYPASS_EN
      w_busy_eff[r] = CMP_W'(w_cnt[r]) > CMP_W'(w_dec[r]);
      if (issue_dst == IDX_W'(r) && w_cnt[r] == '1 && w_dec[r] == '0)
        w_full = issue_dst_valid;
`else
      w_busy_eff[r] = w_nonzero[r];
      if (issue_dst == IDX_W'(r) && w_cnt[r] == '1)
        w_full = issue_dst_valid;
`endif
    end
  end

  assign w_raw       = |(issue_src_mask & w_busy_eff);
  assign issue_ready = !flush && !w_raw && !w_full;
  assign w_fire      = issue_valid && issue_ready;

  // Increment strobe per register from an accepted issue.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      w_inc[r] = w_fire && issue_dst_valid && (issue_dst == IDX_W'(r));
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_cnt
      sb_reg_counter #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_inc[g]),
        .i_dec       (w_dec[g]),
        .i_clr       (flush),
        .o_cnt       (w_cnt[g]),
        .o_nonzero   (w_nonzero[g]),
        .o_underflow (w_underflow[g])
      );
    end
  endgenerate

  // Sticky error on any retire to an idle register (suppressed by flush in the counter).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sb_error <= 1'b0;
    else        r_sb_error <= r_sb_error | (|w_underflow);
  end

  // Saturating count of cycles decode was held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (issue_valid && !issue_ready && (r_stall != '1))
      r_stall <= r_stall + STALL_W'(1);
  end

  assign busy         = w_nonzero;
  assign stall_cycles = r_stall;
  assign sb_error     = r_sb_error;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (16 regs, 2 wb ports, 2-bit counters, 4-bit stall counter).
// Expectations follow SCOREBOARD_BYPASS_EN when the bench is built with it.
// Each scenario task drives its own vectors and checks inline.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [15:0] issue_src_mask;
  logic        issue_dst_valid;
  logic [3:0]  issue_dst;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_dst;
  logic        flush;
  logic [15:0] busy;
  logic [3:0]  stall_cycles;
  logic        sb_error;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.NUM_REGS(16), .WB_PORTS(2), .CNT_W(2), .STALL_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_src_mask  (issue_src_mask),
    .issue_dst_valid (issue_dst_valid),
    .issue_dst       (issue_dst),
    .wb_valid        (wb_valid),
    .wb_dst          (wb_dst),
    .flush           (flush),
    .busy            (busy),
    .stall_cycles    (stall_cycles),
    .sb_error        (sb_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_src_mask = '0; issue_dst_valid = 0; issue_dst = '0;
    wb_valid = '0; wb_dst = '0; flush = 0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 0;
    #2;
    rst_n = 1;
    #1;
  endtask

  task automatic do_issue(input logic [3:0] dst);
    issue_valid = 1; issue_dst_valid = 1; issue_dst = dst; issue_src_mask = '0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got %h want 0000", busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    rst_n = 1;
    tick();
    do_issue(4'd0);
    do_issue(4'd2);
    issue_valid = 1; issue_src_mask = 16'h0001;
    tick();
    checks++; if (busy !== 16'h0005) begin errors++; $display("FAIL midrun_busy got %h want 0005", busy); end
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL midrun_stall got %0d want 1", stall_cycles); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL async_busy got %h want 0000", busy); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL async_stall got %0d want 0", stall_cycles); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL async_err got %b want 0", sb_error); end
    idle();
    #1;
    rst_n = 1;
    tick();
  endtask

  task automatic test_raw();
    apply_reset();
    do_issue(4'd3);
    issue_valid = 1; issue_src_mask = 16'h0008;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_ready got %b want 0", issue_ready); end
    tick();
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL raw_stall1 got %0d want 1", stall_cycles); end
    tick();
    checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL raw_stall2 got %0d want 2", stall_cycles); end
    wb_valid = 2'b01; wb_dst = {4'd0, 4'd3};
    #1;
    checks++; if (issue_ready !== BYP) begin errors++; $display("FAIL raw_wb_ready got %b want %b", issue_ready, BYP); end
    tick();
    wb_valid = '0; wb_dst = '0;
    #1;
    checks++; if (stall_cycles !== (BYP ? 4'd2 : 4'd3)) begin errors++; $display("FAIL raw_stall3 got %0d want %0d", stall_cycles, BYP ? 2 : 3); end
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL raw_busy got %h want 0000", busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_after_ready got %b want 1", issue_ready); end
    tick();
    idle();
  endtask

  task automatic test_waw();
    apply_reset();
    do_issue(4'd5);
    do_issue(4'd5);
    do_issue(4'd5);
    issue_valid = 1; issue_dst_valid = 1; issue_dst = 4'd5;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_full got %b want 0", issue_ready); end
    tick();
    wb_valid = 2'b10; wb_dst = {4'd5, 4'd0};
    #1;
    checks++; if (issue_ready !== BYP) begin errors++; $display("FAIL waw_wb_ready got %b want %b", issue_ready, BYP); end
    tick();
    wb_valid = '0; wb_dst = '0;
    if (!BYP) begin
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_fourth_ready got %b want 1", issue_ready); end
      tick();
    end
    // Fourth writer accepted; counter back at three, so a fifth is held.
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_refull got %b want 0", issue_ready); end
    checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL waw_busy got %h want 0020", busy); end
    idle();
    wb_valid = 2'b11; wb_dst = {4'd5, 4'd5};
    tick();
    wb_valid = 2'b01; wb_dst = {4'd0, 4'd5};
    tick();
    idle();
    checks++; if (busy !== 16'h0 || sb_error !== 1'b0) begin errors++; $display("FAIL waw_drain got busy %h err %b want 0000 0", busy, sb_error); end
  endtask

  task automatic test_dual_retire();
    apply_reset();
    do_issue(4'd7);
    do_issue(4'd7);
    wb_valid = 2'b11; wb_dst = {4'd7, 4'd7};
    tick();
    idle();
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL dual_busy got %h want 0000", busy); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL dual_err got %b want 0", sb_error); end
    wb_valid = 2'b01; wb_dst = {4'd0, 4'd7};
    tick();
    idle();
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL under_err got %b want 1", sb_error); end
    tick();
    tick();
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL sticky_err got %b want 1", sb_error); end
  endtask

  task automatic test_flush();
    logic [3:0] s0;
    apply_reset();
    for (int i = 0; i < 8; i++) do_issue(4'(i));
    checks++; if (busy !== 16'h00FF) begin errors++; $display("FAIL flush_pre_busy got %h want 00FF", busy); end
    s0 = stall_cycles;
    issue_valid = 1; issue_dst_valid = 1; issue_dst = 4'd8; flush = 1;
    wb_valid = 2'b11; wb_dst = {4'd9, 4'd1};
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", issue_ready); end
    tick();
    idle();
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL flush_busy got %h want 0000", busy); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", sb_error); end
    checks++; if (stall_cycles !== s0 + 4'd1) begin errors++; $display("FAIL flush_stall got %0d want %0d", stall_cycles, s0 + 4'd1); end
  endtask

  task automatic test_simul_issue_retire();
    apply_reset();
    do_issue(4'd2);
    issue_valid = 1; issue_dst_valid = 1; issue_dst = 4'd2;
    wb_valid = 2'b01; wb_dst = {4'd0, 4'd2};
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b want 1", issue_ready); end
    tick();
    idle();
    checks++; if (busy !== 16'h0004) begin errors++; $display("FAIL simul_busy got %h want 0004", busy); end
    wb_valid = 2'b01; wb_dst = {4'd0, 4'd2};
    tick();
    idle();
    checks++; if (busy !== 16'h0 || sb_error !== 1'b0) begin errors++; $display("FAIL simul_drain got busy %h err %b want 0000 0", busy, sb_error); end
  endtask

  task automatic test_stall_sat();
    apply_reset();
    do_issue(4'd4);
    issue_valid = 1; issue_src_mask = 16'h0010;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (stall_cycles !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d want 14", stall_cycles); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_cycles); end
    idle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 10; i < 14; i++) begin
      issue_valid = 1; issue_dst_valid = 1; issue_dst = 4'(i); issue_src_mask = 16'h0001;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, issue_ready); end
      tick();
    end
    idle();
    checks++; if (busy !== 16'h3C00 || stall_cycles !== 4'd0) begin errors++; $display("FAIL b2b_state got busy %h stall %0d want 3C00 0", busy, stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_dual_retire();
    test_flush();
    test_simul_issue_retire();
    test_stall_sat();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
